// File: rtl/cache_pkg.sv
// Shared cache constants and miss-handler state encoding.
// Used by the cache core and by cache_mem_ctrl.
package cache_pkg;

   localparam int ASIZE = 32;
   localparam int DSIZE = 32;
   localparam int BBITS = 5;
   localparam int IBITS = 10;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WBACK   = 3'd1,
      FILL    = 3'd2,
      INSTALL = 3'd3,
      RETRY   = 3'd4
   } state_t;

endpackage

// File: rtl/cache_block_shifter.sv
// Word-indexed block access: victim -> wdata, rdata -> block_nxt.
// Ports: victim, block_cur, cnt, rdata in; wdata, block_nxt out.
module cache_block_shifter #(
   parameter int bsize  = 256,
   parameter int dsize  = 32,
   parameter int nwords = bsize / dsize,
   parameter int cw     = (nwords > 1) ? $clog2(nwords) : 1
) (
   input  logic [bsize-1:0] victim,
   input  logic [bsize-1:0] block_cur,
   input  logic [cw-1:0]    cnt,
   input  logic [dsize-1:0] rdata,
   output logic [dsize-1:0] wdata,
   output logic [bsize-1:0] block_nxt
);

   // Word 0 sits at the MSB end of the block.
   always_comb begin
      wdata     = '0;
      block_nxt = block_cur;
      for (int k = 0; k < nwords; k++) begin
         if (cnt == cw'(k)) begin
            wdata = victim[bsize-1-k*dsize -: dsize];
            block_nxt[bsize-1-k*dsize -: dsize] = rdata;
         end
      end
   end

endmodule

// File: rtl/cache_mem_ctrl.sv
// Cache miss handler: victim write-back, block refill, install.
// Ports: CPU request/addr, core hit/dirty/victim, memory word bus.
module cache_mem_ctrl
   import cache_pkg::*;
#(
   parameter int asize  = ASIZE,
   parameter int dsize  = DSIZE,
   parameter int bbits  = BBITS,
   parameter int ibits  = IBITS,
   parameter int tbits  = asize - ibits - bbits,
   parameter int bsize  = 8 << bbits,
   parameter int nwords = bsize / dsize
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             cpu_read,
   input  logic             cpu_write,
   input  logic [asize-1:0] cpu_addr,
   input  logic             hit,
   input  logic             dirty,
   input  logic [tbits-1:0] victim_tag,
   input  logic [bsize-1:0] block_out,
   output logic [bsize-1:0] block_in,
   output logic             bwrite,
   output logic             stall,
   output logic             mem_req,
   output logic             mem_we,
   output logic [asize-1:0] mem_addr,
   output logic [dsize-1:0] mem_wdata,
   input  logic [dsize-1:0] mem_rdata,
   input  logic             mem_ack
);

   localparam int cw = (nwords > 1) ? $clog2(nwords) : 1;
   localparam logic [cw-1:0] last = cw'(nwords - 1);

   state_t           state_q, state_d;
   logic [cw-1:0]    cnt_q;
   logic [tbits-1:0] tag_q, vtag_q;
   logic [ibits-1:0] idx_q;
   logic [bsize-1:0] victim_q, block_nxt;
   logic [dsize-1:0] wdata;
   logic             miss, xfer;
   logic             unused_offset;

   assign unused_offset = ^cpu_addr[bbits-1:0];

   assign miss = (cpu_read | cpu_write) & ~hit;
   // Acks only count while a burst is actually requested.
   assign xfer = mem_ack & ((state_q == WBACK) | (state_q == FILL));

   cache_block_shifter #(
      .bsize (bsize),
      .dsize (dsize),
      .nwords(nwords),
      .cw    (cw)
   ) u_shift (
      .victim   (victim_q),
      .block_cur(block_in),
      .cnt      (cnt_q),
      .rdata    (mem_rdata),
      .wdata    (wdata),
      .block_nxt(block_nxt)
   );

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         block_in <= '0;
         tag_q    <= '0;
         idx_q    <= '0;
         vtag_q   <= '0;
         victim_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && miss) begin
            tag_q    <= cpu_addr[asize-1 -: tbits];
            idx_q    <= cpu_addr[bbits +: ibits];
            vtag_q   <= victim_tag;
            victim_q <= block_out;
            cnt_q    <= '0;
         end
         if (xfer) cnt_q <= cnt_q + cw'(1);
         if (xfer && state_q == FILL) block_in <= block_nxt;
      end
   end

   always_comb begin
      state_d   = state_q;
      stall     = 1'b1;
      bwrite    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      unique case (state_q)
         IDLE: begin
            stall = miss;
            if (miss) state_d = dirty ? WBACK : FILL;
         end
         WBACK: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {vtag_q, idx_q, cnt_q, 2'b00};
            mem_wdata = wdata;
            if (mem_ack && cnt_q == last) state_d = FILL;
         end
         FILL: begin
            mem_req  = 1'b1;
            mem_addr = {tag_q, idx_q, cnt_q, 2'b00};
            if (mem_ack && cnt_q == last) state_d = INSTALL;
         end
         INSTALL: begin
            bwrite  = 1'b1;
            state_d = RETRY;
         end
         RETRY: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

endmodule
